// File: rtl/mips_memory.sv
// rtl/mips_memory.sv - Unified instruction/data memory with program-image loader and CPU reset sequencing
module mips_memory #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_out,
  input  logic [31:0] data_addr,
  input  logic        data_rd_wr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        cpu_reset,
  output logic        fault,
  output logic [31:0] fault_addr
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [29:0]   DEPTH_L  = 30'(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH_WORDS - 1);

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] load_ptr;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   i_off, d_off;
  logic          i_ok, d_ok;
  logic [AW-1:0] i_idx, d_idx;
  logic          running, load_accept;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  // Offsets below BASE_ADDR wrap to huge values, so the range test also needs the >= check.
  assign i_off = instr_addr - BASE_ADDR;
  assign d_off = data_addr - BASE_ADDR;
  assign i_ok  = (instr_addr[1:0] == 2'b00) && (instr_addr >= BASE_ADDR) && (i_off[31:2] < DEPTH_L);
  assign d_ok  = (data_addr[1:0] == 2'b00) && (data_addr >= BASE_ADDR) && (d_off[31:2] < DEPTH_L);
  assign i_idx = i_off[AW+1:2];
  assign d_idx = d_off[AW+1:2];

  assign running     = (state == ST_RUN);
  assign load_ready  = reset && (state == ST_LOAD);
  assign load_accept = load_valid && load_ready;
  assign cpu_reset   = !reset || !running;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = load_ptr;
    mem_wdata = load_data;
    if (load_accept) begin
      mem_we = 1'b1;
    end else if (reset && running && !data_rd_wr && d_ok) begin
      mem_we    = 1'b1;
      mem_waddr = d_idx;
      mem_wdata = data_in;
    end
  end

  // Memory array has no reset so a reset mid-load keeps earlier image words.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_LOAD;
      load_ptr   <= '0;
      instr_out  <= '0;
      data_out   <= '0;
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_accept) begin
            load_ptr <= load_ptr + 1'b1;
            if (load_last || (load_ptr == LAST_PTR)) begin
              state <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: state <= ST_RUN;
        ST_RUN:     state <= ST_RUN;
        default:    state <= ST_LOAD;
      endcase

      if (running) begin
        instr_out <= i_ok ? mem[i_idx] : '0;
        if (data_rd_wr) begin
          data_out <= d_ok ? mem[d_idx] : '0;
        end
        // Data port wins the capture when both ports fault on the first bad cycle.
        if (!fault && !(i_ok && d_ok)) begin
          fault      <= 1'b1;
          fault_addr <= d_ok ? instr_addr : data_addr;
        end
      end else begin
        instr_out <= '0;
        data_out  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mips_memory.sv
// tb/tb_mips_memory.sv - Scoreboard bench for mips_memory against an array reference model
module tb_mips_memory;
  localparam int DEPTH = 1024;
  localparam longint unsigned BASE = 0;

  localparam int S_INSTR = 0, S_DATA = 1, S_CPURST = 2, S_READY = 3, S_FAULT = 4, S_FADDR = 5;
  localparam int S_SREADY = 6, S_SCPURST = 7, S_SINSTR = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] instr_addr = 32'h0, data_addr = 32'h0, data_in = 32'h0, load_data = 32'h0;
  logic        data_rd_wr = 1'b1, load_valid = 1'b0, load_last = 1'b0;
  logic [31:0] instr_out, data_out, fault_addr;
  logic        load_ready, cpu_reset, fault;

  logic [31:0] s_instr_addr = 32'h0, s_data_addr = 32'h0, s_data_in = 32'h0, s_load_data = 32'h0;
  logic        s_data_rd_wr = 1'b1, s_load_valid = 1'b0, s_load_last = 1'b0;
  logic [31:0] s_instr_out, s_data_out, s_fault_addr;
  logic        s_load_ready, s_cpu_reset, s_fault;

  mips_memory #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0)) u_dut (
    .clk(clk), .reset(reset),
    .instr_addr(instr_addr), .instr_out(instr_out),
    .data_addr(data_addr), .data_rd_wr(data_rd_wr), .data_in(data_in), .data_out(data_out),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .cpu_reset(cpu_reset), .fault(fault), .fault_addr(fault_addr)
  );

  mips_memory #(.DEPTH_WORDS(4), .BASE_ADDR(32'h0)) u_small (
    .clk(clk), .reset(reset),
    .instr_addr(s_instr_addr), .instr_out(s_instr_out),
    .data_addr(s_data_addr), .data_rd_wr(s_data_rd_wr), .data_in(s_data_in), .data_out(s_data_out),
    .load_valid(s_load_valid), .load_ready(s_load_ready), .load_data(s_load_data), .load_last(s_load_last),
    .cpu_reset(s_cpu_reset), .fault(s_fault), .fault_addr(s_fault_addr)
  );

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  bit          known [DEPTH];
  int          m_ptr;
  logic [31:0] m_dout;
  bit          m_dout_known;
  bit          m_fault;
  logic [31:0] m_faddr;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      S_INSTR:   return instr_out;
      S_DATA:    return data_out;
      S_CPURST:  return {31'b0, cpu_reset};
      S_READY:   return {31'b0, load_ready};
      S_FAULT:   return {31'b0, fault};
      S_FADDR:   return fault_addr;
      S_SREADY:  return {31'b0, s_load_ready};
      S_SCPURST: return {31'b0, s_cpu_reset};
      default:   return s_instr_out;
    endcase
  endfunction

  always @(posedge clk) begin
    chk_t c;
    #1;
    cyc++;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      c = sbq.pop_front();
      checks++;
      if (c.cyc < cyc) begin
        errors++;
        $display("FAIL %s: check missed its cycle %0d (now %0d)", c.name, c.cyc, cyc);
      end else if (actual(c.sel) !== c.exp) begin
        errors++;
        $display("FAIL %s @%0d: actual=%h expected=%h", c.name, cyc, actual(c.sel), c.exp);
      end
    end
  end

  task automatic exp_push(int dly, int sel, logic [31:0] v, string nm);
    chk_t e;
    int   i;
    e.cyc = cyc + dly; e.sel = sel; e.exp = v; e.name = nm;
    i = sbq.size();
    while (i > 0 && sbq[i-1].cyc > e.cyc) i--;
    sbq.insert(i, e);
  endtask

  function automatic bit addr_ok(logic [31:0] a);
    longint unsigned la = 64'(a);
    if (la % 4 != 0) return 1'b0;
    if (la < BASE) return 1'b0;
    return ((la - BASE) / 4) < DEPTH;
  endfunction

  function automatic int addr_idx(logic [31:0] a);
    return int'((64'(a) - BASE) / 4);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(int n);
    reset = 1'b0; load_valid = 1'b0; load_last = 1'b0; s_load_valid = 1'b0;
    exp_push(1, S_INSTR, 32'h0, "rst_instr_out");
    exp_push(1, S_DATA, 32'h0, "rst_data_out");
    exp_push(1, S_CPURST, 32'h1, "rst_cpu_reset");
    exp_push(1, S_READY, 32'h0, "rst_load_ready");
    exp_push(1, S_FAULT, 32'h0, "rst_fault");
    exp_push(1, S_FADDR, 32'h0, "rst_fault_addr");
    repeat (n) tick();
    m_ptr = 0; m_dout = 32'h0; m_dout_known = 1'b1; m_fault = 1'b0; m_faddr = 32'h0;
    reset = 1'b1;
    exp_push(1, S_READY, 32'h1, "ready_after_reset");
    tick();
  endtask

  task automatic load_beat(logic [31:0] d, bit last);
    bit done;
    load_valid = 1'b1; load_data = d; load_last = last;
    instr_addr = 32'h3; data_addr = 32'h5; data_rd_wr = 1'b0;
    ref_mem[m_ptr] = d; known[m_ptr] = 1'b1;
    m_ptr++;
    done = last || (m_ptr == DEPTH);
    exp_push(1, S_READY, done ? 32'h0 : 32'h1, "load_ready_beat");
    exp_push(1, S_CPURST, 32'h1, "cpu_reset_load");
    exp_push(1, S_INSTR, 32'h0, "instr_out_load");
    exp_push(1, S_FAULT, 32'h0, "fault_load");
    if (done) begin
      exp_push(2, S_CPURST, 32'h0, "cpu_reset_run");
      exp_push(2, S_READY, 32'h0, "load_ready_run");
      exp_push(2, S_FAULT, 32'h0, "fault_release");
      exp_push(2, S_DATA, 32'h0, "data_out_release");
    end
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    if (done) begin
      tick();
      instr_addr = 32'h0; data_addr = 32'h0; data_rd_wr = 1'b1;
    end
  endtask

  task automatic run_op(logic [31:0] ia, logic [31:0] da, bit rd, logic [31:0] din);
    bit iv, dv;
    instr_addr = ia; data_addr = da; data_rd_wr = rd; data_in = din;
    iv = addr_ok(ia); dv = addr_ok(da);
    if (!iv) exp_push(1, S_INSTR, 32'h0, "instr_out_invalid");
    else if (known[addr_idx(ia)]) exp_push(1, S_INSTR, ref_mem[addr_idx(ia)], "instr_out");
    if (rd) begin
      m_dout = dv ? ref_mem[addr_idx(da)] : 32'h0;
      m_dout_known = dv ? known[addr_idx(da)] : 1'b1;
    end
    if (m_dout_known) exp_push(1, S_DATA, m_dout, rd ? "data_out_read" : "data_out_hold");
    if (!m_fault && (!iv || !dv)) begin
      m_fault = 1'b1;
      m_faddr = !dv ? da : ia;
    end
    exp_push(1, S_FAULT, {31'b0, m_fault}, "fault");
    exp_push(1, S_FADDR, m_faddr, "fault_addr");
    if (!rd && dv) begin
      ref_mem[addr_idx(da)] = din;
      known[addr_idx(da)] = 1'b1;
    end
    tick();
  endtask

  function automatic logic [31:0] rand_addr(bit allow_bad);
    int r = $urandom_range(0, 9);
    if (allow_bad && r == 0) return 32'($urandom_range(0, 47) * 4 + $urandom_range(1, 3));
    if (allow_bad && r == 1) return 32'h1000 + 32'($urandom_range(0, 100) * 4);
    return 32'($urandom_range(0, 47) * 4);
  endfunction

  initial begin
    int n;
    logic [31:0] sdat [6];
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    tick();
    do_reset(3);

    // Three-word program with load_last on the final beat
    load_beat(32'h24020005, 1'b0);
    load_beat(32'h00000000, 1'b0);
    load_beat(32'h0800000F, 1'b1);
    run_op(32'h4, 32'h0, 1'b1, 32'h0);
    run_op(32'h8, 32'h8, 1'b1, 32'h0);

    // Reset mid-load restarts at word 0, earlier words kept
    do_reset(2);
    load_beat(32'hA0A0A0A0, 1'b0);
    load_beat(32'hB1B1B1B1, 1'b0);
    do_reset(1);
    load_beat(32'hC2C2C2C2, 1'b1);
    run_op(32'h0, 32'h4, 1'b1, 32'h0);
    run_op(32'h8, 32'h0, 1'b1, 32'h0);

    // Random image then random valid traffic
    do_reset(1);
    n = $urandom_range(16, 40);
    for (int i = 0; i < n; i++) load_beat($urandom, i == n - 1);
    for (int i = 0; i < 300; i++) begin
      a = rand_addr(1'b0);
      if ($urandom_range(0, 3) == 0) begin
        run_op(rand_addr(1'b0), a, 1'b0, $urandom);
        if ($urandom_range(0, 1) == 1) run_op(rand_addr(1'b0), a, 1'b0, data_in);
      end else begin
        run_op(rand_addr(1'b0), a, 1'b1, 32'h0);
      end
    end

    // Write with same-word fetch, repeated write, then read back
    run_op(32'h10, 32'h10, 1'b0, 32'hDEADBEEF);
    run_op(32'h10, 32'h10, 1'b0, 32'hDEADBEEF);
    run_op(32'h0, 32'h10, 1'b1, 32'h0);

    // Misaligned write faults and is dropped; out-of-range read returns 0
    run_op(32'h0, 32'h12, 1'b0, 32'h12345678);
    run_op(32'h0, 32'h1000, 1'b1, 32'h0);
    run_op(32'h10, 32'h10, 1'b1, 32'h0);
    for (int i = 0; i < 100; i++) begin
      run_op(rand_addr(1'b1), rand_addr(1'b1), 1'($urandom_range(0, 1)), $urandom);
    end

    // Both ports fault on the first bad cycle: data address wins
    do_reset(1);
    load_beat($urandom, 1'b1);
    run_op(32'h2000, 32'h3, 1'b0, 32'h55555555);
    run_op(32'h4, 32'h8, 1'b1, 32'h0);

    // Small instance: 6 beats into a 4-word memory, no load_last
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      sdat[i] = $urandom;
      s_load_valid = 1'b1; s_load_data = sdat[i];
      exp_push(1, S_SREADY, (i < 3) ? 32'h1 : 32'h0, "small_load_ready");
      exp_push(1, S_SCPURST, (i <= 3) ? 32'h1 : 32'h0, "small_cpu_reset");
      tick();
    end
    s_load_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_instr_addr = 32'(k * 4);
      exp_push(1, S_SINSTR, sdat[k], "small_word");
      tick();
    end

    for (int i = 0; i < 20 && sbq.size() > 0; i++) tick();
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d checks still pending, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_memory.md
MIPS_MEMORY -- requirements
Module: mips_memory

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored (power of two, >= 2).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0: byte address of word 0 (word-aligned).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port instr_addr, input, 32: instruction fetch byte address from the processor.
REQ-006 SHALL have port instr_out, output, 32: fetched instruction word.
REQ-007 SHALL have port data_addr, input, 32: data byte address from the processor.
REQ-008 SHALL have port data_rd_wr, input, 1: 1 = read, 0 = write.
REQ-009 SHALL have port data_in, input, 32: store data from the processor.
REQ-010 SHALL have port data_out, output, 32: load data to the processor.
REQ-011 SHALL have ports load_valid (input, 1), load_ready (output, 1), load_data (input, 32), load_last (input, 1): program-image loader stream.
REQ-012 SHALL have port cpu_reset, output, 1: active-high reset driven to the processor.
REQ-013 SHALL have ports fault (output, 1) and fault_addr (output, 32): sticky access-fault flag and first faulting address.

Function
REQ-014 SHALL implement FSM states LOAD, RELEASE, RUN; LOAD is entered on reset.
REQ-015 In LOAD: load_ready = 1, cpu_reset = 1; each cycle with load_valid & load_ready writes load_data to word load_ptr, then load_ptr increments.
REQ-016 LOAD -> RELEASE on an accepted beat with load_last = 1, or on an accepted beat at load_ptr = DEPTH_WORDS-1 (full), whichever comes first; no further beats are accepted.
REQ-017 RELEASE lasts exactly one cycle with cpu_reset = 1 and load_ready = 0, then -> RUN.
REQ-018 In RUN: cpu_reset = 0, load_ready = 0; load_valid ignored; RUN is left only by reset.
REQ-019 Word index = (addr - BASE_ADDR) >> 2; an access is valid iff addr[1:0] = 0, addr >= BASE_ADDR, and index < DEPTH_WORDS.
REQ-020 In RUN, instr_out SHALL register mem[index(instr_addr)] every cycle (1-cycle latency); invalid address -> 0.
REQ-021 In RUN with data_rd_wr = 1, data_out SHALL register mem[index(data_addr)] (1-cycle latency); invalid address -> 0.
REQ-022 In RUN with data_rd_wr = 0 and a valid address, data_in SHALL be written to mem[index(data_addr)] at the clock edge; data_out holds its previous value.
REQ-023 Repeated identical writes on consecutive cycles SHALL be harmless (idempotent).
REQ-024 A write and an instruction read to the same word in one cycle: instr_out SHALL return the pre-write value (read-before-write).
REQ-025 An invalid write SHALL be suppressed (memory unchanged).
REQ-026 Any invalid access in RUN SHALL set fault = 1; fault_addr SHALL capture the first faulting address only; if both ports fault in the same first cycle, data_addr is captured.
REQ-027 In LOAD and RELEASE, instr/data ports SHALL be ignored: no writes, instr_out = data_out = 0, no faults.

Reset
REQ-028 While reset = 0: state -> LOAD, load_ptr = 0, instr_out = 0, data_out = 0, cpu_reset = 1, load_ready = 0, fault = 0, fault_addr = 0.
REQ-029 Memory contents SHALL NOT be cleared by reset; reset mid-load restarts loading at word 0 with earlier words retained.
REQ-030 load_ready SHALL rise in the first cycle after reset returns to 1.

Verification
REQ-031 Load 3 words {0x24020005, 0x00000000, 0x0800000F} with load_last on beat 3 -> cpu_reset high through RELEASE cycle, low next cycle; instr_addr=0x4 -> instr_out=0x00000000 one cycle later; instr_addr=0x8 -> 0x0800000F.
REQ-032 DEPTH_WORDS=4, stream 6 beats without load_last -> only 4 accepted, load_ready drops after beat 4, RUN reached 2 cycles after beat 4.
REQ-033 RUN: write 0xDEADBEEF to 0x10, read 0x10 next cycle -> data_out=0xDEADBEEF one cycle after the read address is presented; same-cycle instr_addr=0x10 during write -> old value.
REQ-034 RUN: write to 0x12 then read 0x1000 (DEPTH 1024) -> fault=1, fault_addr=0x12, word 0x10 unchanged, read returns 0.
REQ-035 Assert reset for 1 cycle after 2 load beats -> load_ptr=0, re-load overwrites word 0; earlier word 1 still readable in RUN.
